// File: rtl/ycbcr_binarize.sv
// Cb/Cr window binarizer: 2-stage pipeline emitting a DE-qualified mask with matched sync latency.
// Define FRAME_STATS_EN to build the per-frame foreground pixel counter (white_count/count_valid).
module ycbcr_binarize #(
  parameter logic [7:0]  CB_MIN_DEF = 8'd77,
  parameter logic [7:0]  CB_MAX_DEF = 8'd127,
  parameter logic [7:0]  CR_MIN_DEF = 8'd133,
  parameter logic [7:0]  CR_MAX_DEF = 8'd173,
  parameter int unsigned CNT_W      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  input  logic [23:0]      pixel_in,
  input  logic [7:0]       cb_min,
  input  logic [7:0]       cb_max,
  input  logic [7:0]       cr_min,
  input  logic [7:0]       cr_max,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic             mask_out,
  output logic [23:0]      pixel_out,
  output logic [CNT_W-1:0] white_count,
  output logic             count_valid
);

  logic [7:0] cb;
  logic [7:0] cr;
  logic       unused_y;

  assign cb       = pixel_in[15:8];
  assign cr       = pixel_in[7:0];
  assign unused_y = ^pixel_in[23:16];

  // Stage-1 / stage-2 pipeline registers
  logic hsync_q1, vsync_q1, de_q1, hit_q1;
  logic hsync_q2, vsync_q2, de_q2, mask_q2;

  // Active (shadowed) thresholds
  logic [7:0] cb_min_q, cb_min_d;
  logic [7:0] cb_max_q, cb_max_d;
  logic [7:0] cr_min_q, cr_min_d;
  logic [7:0] cr_max_q, cr_max_d;

  logic boundary;
  logic hit;

  assign boundary = vsync_in & ~vsync_q1;

  // An inverted window (min > max) can never be satisfied, so it yields hit=0 naturally.
  assign hit = (cb >= cb_min_q) && (cb <= cb_max_q) &&
               (cr >= cr_min_q) && (cr <= cr_max_q);

  always_comb begin
    cb_min_d = cb_min_q;
    cb_max_d = cb_max_q;
    cr_min_d = cr_min_q;
    cr_max_d = cr_max_q;
    if (boundary) begin
      cb_min_d = cb_min;
      cb_max_d = cb_max;
      cr_min_d = cr_min;
      cr_max_d = cr_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cb_min_q <= CB_MIN_DEF;
      cb_max_q <= CB_MAX_DEF;
      cr_min_q <= CR_MIN_DEF;
      cr_max_q <= CR_MAX_DEF;
    end else begin
      cb_min_q <= cb_min_d;
      cb_max_q <= cb_max_d;
      cr_min_q <= cr_min_d;
      cr_max_q <= cr_max_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q1 <= 1'b0;
      vsync_q1 <= 1'b0;
      de_q1    <= 1'b0;
      hit_q1   <= 1'b0;
      hsync_q2 <= 1'b0;
      vsync_q2 <= 1'b0;
      de_q2    <= 1'b0;
      mask_q2  <= 1'b0;
    end else begin
      hsync_q1 <= hsync_in;
      vsync_q1 <= vsync_in;
      de_q1    <= de_in;
      hit_q1   <= hit & de_in;
      hsync_q2 <= hsync_q1;
      vsync_q2 <= vsync_q1;
      de_q2    <= de_q1;
      mask_q2  <= hit_q1;
    end
  end

  assign hsync_out = hsync_q2;
  assign vsync_out = vsync_q2;
  assign de_out    = de_q2;
  assign mask_out  = mask_q2;
  assign pixel_out = {24{mask_q2}};

`ifdef FRAME_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] white_q, white_d;
  logic             pub_q1;
  logic             valid_q;

  // The count is captured at the boundary and published one cycle later so it lines up with vsync_out.
  always_comb begin
    acc_d   = acc_q;
    pend_d  = pend_q;
    white_d = white_q;
    if (boundary) begin
      acc_d  = '0;
      pend_d = acc_q;
    end else if (de_in && hit && (acc_q != {CNT_W{1'b1}})) begin
      acc_d = acc_q + CNT_ONE;
    end
    if (pub_q1) begin
      white_d = pend_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      pend_q  <= '0;
      white_q <= '0;
      pub_q1  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      white_q <= white_d;
      pub_q1  <= boundary;
      valid_q <= pub_q1;
    end
  end

  assign white_count = white_q;
  assign count_valid = valid_q;
`else
  assign white_count = '0;
  assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ycbcr_binarize.sv
// Directed self-checking bench for ycbcr_binarize; a second CNT_W=4 instance covers counter saturation.
module tb_ycbcr_binarize;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in, de_in;
  logic [23:0] pixel_in;
  logic [7:0]  cb_min, cb_max, cr_min, cr_max;
  logic        hsync_out, vsync_out, de_out, mask_out, count_valid;
  logic [23:0] pixel_out;
  logic [21:0] white_count;
  logic        s_hsync_out, s_vsync_out, s_de_out, s_mask_out, s_count_valid;
  logic [23:0] s_pixel_out;
  logic [3:0]  s_white_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ycbcr_binarize #(.CNT_W(22)) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .pixel_in(pixel_in), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .mask_out(mask_out),
    .pixel_out(pixel_out), .white_count(white_count), .count_valid(count_valid)
  );

  ycbcr_binarize #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .pixel_in(pixel_in), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .hsync_out(s_hsync_out), .vsync_out(s_vsync_out), .de_out(s_de_out), .mask_out(s_mask_out),
    .pixel_out(s_pixel_out), .white_count(s_white_count), .count_valid(s_count_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic v, input logic d,
                       input logic [7:0] cbv, input logic [7:0] crv);
    hsync_in = h;
    vsync_in = v;
    de_in    = d;
    pixel_in = {8'd90, cbv, crv};
  endtask

  task automatic frame_boundary();
    drive(0, 1, 0, 8'd0, 8'd0);
    tick();
    drive(0, 0, 0, 8'd0, 8'd0);
    tick();
  endtask

  task automatic test_reset();
    cb_min = 8'd77; cb_max = 8'd127; cr_min = 8'd133; cr_max = 8'd173;
    rst = 1'b1;
    drive(1, 1, 1, 8'd100, 8'd150);
    tick(); tick();
    checks++;
    if ({hsync_out, vsync_out, de_out, mask_out, pixel_out} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", {hsync_out, vsync_out, de_out, mask_out, pixel_out});
    end
    checks++;
    if ({white_count, count_valid} !== 23'h0) begin
      errors++;
      $display("FAIL reset_stats: got wc=%0d cv=%0b expected 0/0", white_count, count_valid);
    end
    drive(0, 0, 1, 8'd100, 8'd150);
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({mask_out, pixel_out} !== {1'b1, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL reset_default_window: got mask=%0b pix=%h expected 1/FFFFFF", mask_out, pixel_out);
    end
    $display("test_reset: done, checks=%0d", checks);
  endtask

  task automatic test_window_edges();
    logic [7:0] cbs [8];
    logic [7:0] crs [8];
    logic       exp [8];
    cbs = '{8'd77, 8'd127, 8'd100, 8'd100, 8'd76, 8'd128, 8'd100, 8'd100};
    crs = '{8'd150, 8'd150, 8'd133, 8'd173, 8'd150, 8'd150, 8'd132, 8'd174};
    exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, cbs[i], crs[i]);
      tick(); tick();
      checks++;
      if ({mask_out, pixel_out} !== {exp[i], {24{exp[i]}}}) begin
        errors++;
        $display("FAIL window_edge cb=%0d cr=%0d: got mask=%0b pix=%h expected %0b", cbs[i], crs[i],
                 mask_out, pixel_out, exp[i]);
      end
    end
    $display("test_window_edges: done, checks=%0d", checks);
  endtask

  task automatic test_latency();
    logic [9:0] hv;
    logic [9:0] vv;
    logic [9:0] dv;
    logic [3:0] exp_o;
    hv = 10'b00_0100_0110;
    vv = 10'b00_0011_1000;
    dv = 10'b01_1110_0100;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(hv[i], vv[i], dv[i], 8'd100, 8'd150);
      else        drive(0, 0, 0, 8'd100, 8'd150);
      tick();
      if (i >= 1) begin
        exp_o = {hv[i-1], vv[i-1], dv[i-1], dv[i-1]};
        checks++;
        if ({hsync_out, vsync_out, de_out, mask_out} !== exp_o ||
            pixel_out !== {24{dv[i-1]}}) begin
          errors++;
          $display("FAIL latency[%0d]: got h/v/de/mask=%b pix=%h expected %b", i - 1,
                   {hsync_out, vsync_out, de_out, mask_out}, pixel_out, exp_o);
        end
      end
    end
    $display("test_latency: done, checks=%0d", checks);
  endtask

  task automatic test_shadowing();
    cb_min = 8'd200;
    drive(0, 0, 1, 8'd100, 8'd150);
    tick(); tick();
    checks++;
    if (mask_out !== 1'b1) begin
      errors++;
      $display("FAIL shadow_midframe: got mask=%0b expected 1", mask_out);
    end
    frame_boundary();
    drive(0, 0, 1, 8'd100, 8'd150);
    tick(); tick();
    checks++;
    if ({mask_out, pixel_out} !== 25'h0) begin
      errors++;
      $display("FAIL shadow_after_vsync: got mask=%0b pix=%h expected 0", mask_out, pixel_out);
    end
    cb_min = 8'd77;
    frame_boundary();
    $display("test_shadowing: done, checks=%0d", checks);
  endtask

  task automatic test_inversion();
    logic [7:0] cbs [5];
    cbs = '{8'd100, 8'd150, 8'd200, 8'd255, 8'd0};
    cb_min = 8'd200;
    cb_max = 8'd100;
    frame_boundary();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, cbs[i], 8'd150);
      tick(); tick();
      checks++;
      if (mask_out !== 1'b0) begin
        errors++;
        $display("FAIL inversion cb=%0d: got mask=%0b expected 0", cbs[i], mask_out);
      end
    end
    cb_min = 8'd77;
    cb_max = 8'd127;
    frame_boundary();
    drive(0, 0, 1, 8'd100, 8'd150);
    tick(); tick();
    checks++;
    if (mask_out !== 1'b1) begin
      errors++;
      $display("FAIL inversion_restore: got mask=%0b expected 1", mask_out);
    end
    $display("test_inversion: done, checks=%0d", checks);
  endtask

  task automatic test_counting();
`ifdef FRAME_STATS_EN
    int hits [3];
    int exp_s;
    hits = '{37, 0, 20};
    frame_boundary();
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < hits[f] + 10; p++) begin
        if (p < hits[f])        drive(p[0], 0, 1, 8'd100, 8'd150);
        else if (p[0] == 1'b0)  drive(0, 0, 1, 8'd50, 8'd150);
        else                    drive(0, 0, 0, 8'd100, 8'd150);
        tick();
      end
      exp_s = (hits[f] > 15) ? 15 : hits[f];
      drive(0, 1, 0, 8'd100, 8'd150);
      tick();
      checks++;
      if (count_valid !== 1'b0 || vsync_out !== 1'b0) begin
        errors++;
        $display("FAIL count_early[%0d]: got cv=%0b vs=%0b expected 0/0", f, count_valid, vsync_out);
      end
      tick();
      checks++;
      if (count_valid !== 1'b1 || vsync_out !== 1'b1 || white_count !== 22'(hits[f])) begin
        errors++;
        $display("FAIL count_pulse[%0d]: got cv=%0b vs=%0b wc=%0d expected 1/1/%0d", f,
                 count_valid, vsync_out, white_count, hits[f]);
      end
      checks++;
      if (s_count_valid !== 1'b1 || s_white_count !== 4'(exp_s)) begin
        errors++;
        $display("FAIL count_sat[%0d]: got cv=%0b wc=%0d expected 1/%0d", f, s_count_valid,
                 s_white_count, exp_s);
      end
      tick();
      checks++;
      if (count_valid !== 1'b0 || white_count !== 22'(hits[f])) begin
        errors++;
        $display("FAIL count_hold[%0d]: got cv=%0b wc=%0d expected 0/%0d", f, count_valid,
                 white_count, hits[f]);
      end
      drive(0, 0, 0, 8'd0, 8'd0);
      tick();
      $display("test_counting: frame %0d hits=%0d wc=%0d sat_wc=%0d", f, hits[f], white_count, s_white_count);
    end
`else
    for (int p = 0; p < 12; p++) begin
      if (p == 8 || p == 9) drive(0, 1, 0, 8'd100, 8'd150);
      else                  drive(0, 0, 1, 8'd100, 8'd150);
      tick();
      checks++;
      if (white_count !== 22'd0 || count_valid !== 1'b0 || s_white_count !== 4'd0) begin
        errors++;
        $display("FAIL stats_disabled[%0d]: got wc=%0d cv=%0b expected 0/0", p, white_count, count_valid);
      end
    end
    drive(0, 0, 0, 8'd0, 8'd0);
    tick();
    $display("test_counting: stats disabled, checks=%0d", checks);
`endif
  endtask

  task automatic test_midframe_reset();
    drive(1, 0, 1, 8'd100, 8'd150);
    tick(); tick();
    checks++;
    if ({hsync_out, de_out, mask_out} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset: got h/de/mask=%b expected 111", {hsync_out, de_out, mask_out});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hsync_out, vsync_out, de_out, mask_out, pixel_out, count_valid} !== 29'h0) begin
      errors++;
      $display("FAIL midframe_reset: got %h expected 0",
               {hsync_out, vsync_out, de_out, mask_out, pixel_out, count_valid});
    end
    tick();
    rst = 1'b0;
`ifdef FRAME_STATS_EN
    for (int p = 0; p < 5; p++) begin
      drive(0, 0, 1, 8'd100, 8'd150);
      tick();
    end
    drive(0, 1, 0, 8'd100, 8'd150);
    tick(); tick();
    checks++;
    if (count_valid !== 1'b1 || white_count !== 22'd5) begin
      errors++;
      $display("FAIL restart_count: got cv=%0b wc=%0d expected 1/5", count_valid, white_count);
    end
    drive(0, 0, 0, 8'd0, 8'd0);
    tick();
`endif
    $display("test_midframe_reset: done, checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_window_edges();
    test_latency();
    test_shadowing();
    test_inversion();
    test_counting();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
